// File: rtl/ctrl_unit_seq_if.sv
// Decoder-side bundle for ctrl_unit_seq: instruction fields and memory
// handshake in, registered ID/EX controls and freeze/error status out.
interface ctrl_unit_seq_if #(
    parameter int unsigned EXE_CMD_W = 4
);
    logic                 valid_in;
    logic                 flush;
    logic [1:0]           mode;
    logic [3:0]           opcode;
    logic                 s_bit;
    logic                 mem_ready;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 s_update;
    logic                 branch;
    logic                 mem_w_en;
    logic                 mem_r_en;
    logic                 wb_en;
    logic                 valid_out;
    logic                 illegal;
    logic                 freeze;
    logic                 mem_err;

    modport master (
        output valid_in, flush, mode, opcode, s_bit, mem_ready,
        input  exe_cmd, s_update, branch, mem_w_en, mem_r_en, wb_en,
               valid_out, illegal, freeze, mem_err
    );

    modport slave (
        input  valid_in, flush, mode, opcode, s_bit, mem_ready,
        output exe_cmd, s_update, branch, mem_w_en, mem_r_en, wb_en,
               valid_out, illegal, freeze, mem_err
    );
endinterface

// File: rtl/ctrl_unit_seq.sv
// Registered ARM control decoder at the ID/EX boundary; holds its outputs and
// freezes upstream while a load/store waits on memory, with optional timeout.
module ctrl_unit_seq #(
    parameter int unsigned EXE_CMD_W   = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst,
    ctrl_unit_seq_if.slave bus
);
    localparam int unsigned    CNT_W      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit             TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_e;

    typedef struct packed {
        logic [3:0] cmd;
        logic       s_upd;
        logic       branch;
        logic       mem_w;
        logic       mem_r;
        logic       wb;
        logic       ill;
    } dec_t;

    dec_t dec;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [EXE_CMD_W-1:0] exe_cmd_q, exe_cmd_d;
    logic                 s_update_q, s_update_d;
    logic                 branch_q, branch_d;
    logic                 mem_w_en_q, mem_w_en_d;
    logic                 mem_r_en_q, mem_r_en_d;
    logic                 wb_en_q, wb_en_d;
    logic                 valid_q, valid_d;
    logic                 illegal_q, illegal_d;
    logic                 mem_err_q, mem_err_d;
    logic                 load_dec, load_bub;

    always_comb begin
        dec = '0;
        case (bus.mode)
            2'b00: begin
                dec.wb    = 1'b1;
                dec.s_upd = bus.s_bit;
                case (bus.opcode)
                    4'b1101: dec.cmd = 4'b0001;
                    4'b1111: dec.cmd = 4'b1001;
                    4'b0100: dec.cmd = 4'b0010;
                    4'b0101: dec.cmd = 4'b0011;
                    4'b0010: dec.cmd = 4'b0100;
                    4'b0110: dec.cmd = 4'b0101;
                    4'b0000: dec.cmd = 4'b0110;
                    4'b1100: dec.cmd = 4'b0111;
                    4'b0001: dec.cmd = 4'b1000;
                    // Compare/test: always set flags, never write back
                    4'b1010: begin dec.cmd = 4'b0100; dec.s_upd = 1'b1; dec.wb = 1'b0; end
                    4'b1000: begin dec.cmd = 4'b0110; dec.s_upd = 1'b1; dec.wb = 1'b0; end
                    default: begin dec = '0; dec.ill = 1'b1; end
                endcase
            end
            2'b01: begin
                dec.cmd   = 4'b0010;
                dec.mem_r = bus.s_bit;
                dec.mem_w = ~bus.s_bit;
                dec.wb    = bus.s_bit;
            end
            2'b10: dec.branch = 1'b1;
            default: dec.ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_dec   = 1'b0;
        load_bub   = 1'b0;
        mem_err_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.valid_in && !bus.flush) begin
                    load_dec = 1'b1;
                    if (bus.mode == 2'b01) begin
                        state_d = ST_MEM_WAIT;
                        cnt_d   = '0;
                    end
                end else begin
                    load_bub = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    load_bub = 1'b1;
                    state_d  = ST_RUN;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    load_bub  = 1'b1;
                    mem_err_d = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        exe_cmd_d  = exe_cmd_q;
        s_update_d = s_update_q;
        branch_d   = branch_q;
        mem_w_en_d = mem_w_en_q;
        mem_r_en_d = mem_r_en_q;
        wb_en_d    = wb_en_q;
        valid_d    = valid_q;
        illegal_d  = 1'b0;
        if (load_dec) begin
            exe_cmd_d  = EXE_CMD_W'(dec.cmd);
            s_update_d = dec.s_upd;
            branch_d   = dec.branch;
            mem_w_en_d = dec.mem_w;
            mem_r_en_d = dec.mem_r;
            wb_en_d    = dec.wb;
            valid_d    = 1'b1;
            illegal_d  = dec.ill;
        end else if (load_bub) begin
            exe_cmd_d  = '0;
            s_update_d = 1'b0;
            branch_d   = 1'b0;
            mem_w_en_d = 1'b0;
            mem_r_en_d = 1'b0;
            wb_en_d    = 1'b0;
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            exe_cmd_q  <= '0;
            s_update_q <= 1'b0;
            branch_q   <= 1'b0;
            mem_w_en_q <= 1'b0;
            mem_r_en_q <= 1'b0;
            wb_en_q    <= 1'b0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exe_cmd_q  <= exe_cmd_d;
            s_update_q <= s_update_d;
            branch_q   <= branch_d;
            mem_w_en_q <= mem_w_en_d;
            mem_r_en_q <= mem_r_en_d;
            wb_en_q    <= wb_en_d;
            valid_q    <= valid_d;
            illegal_q  <= illegal_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign bus.exe_cmd   = exe_cmd_q;
    assign bus.s_update  = s_update_q;
    assign bus.branch    = branch_q;
    assign bus.mem_w_en  = mem_w_en_q;
    assign bus.mem_r_en  = mem_r_en_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.valid_out = valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.mem_err   = mem_err_q;
    assign bus.freeze    = (state_q == ST_MEM_WAIT);
endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Bench for ctrl_unit_seq: directed scenarios then random traffic, all checked
// cycle by cycle against a table-driven reference model.
module tb_ctrl_unit_seq;
    localparam int unsigned W  = 4;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_unit_seq_if #(.EXE_CMD_W(W)) bus ();
    ctrl_unit_seq #(.EXE_CMD_W(W), .MEM_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cmd;
        bit s, br, mw, mr, wb, vo, ill, err;
    } exp_t;

    int   alu_op[11]  = '{13, 15, 4, 5, 2, 6, 0, 12, 1, 10, 8};
    int   alu_cmd[11] = '{ 1,  9, 2, 3, 4, 5, 6,  7, 8,  4, 6};
    exp_t e;
    bit   m_wait;
    int   m_waited;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t decode_ref(int mode, int op, bit s);
        exp_t r = '{default: 0};
        r.vo = 1;
        case (mode)
            0: begin
                r.ill = 1;
                for (int i = 0; i < 11; i++) begin
                    if (alu_op[i] == op) begin
                        r.ill = 0;
                        r.cmd = alu_cmd[i];
                        r.s   = (i >= 9) ? 1'b1 : s;
                        r.wb  = (i < 9);
                    end
                end
            end
            1: begin
                r.cmd = 2;
                r.mr  = s;
                r.mw  = !s;
                r.wb  = s;
            end
            2: r.br = 1;
            default: r.ill = 1;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        exp_t bub = '{default: 0};
        if (rst) begin
            e      = bub;
            m_wait = 0;
        end else if (!m_wait) begin
            if (bus.valid_in && !bus.flush) begin
                e = decode_ref(int'(bus.mode), int'(bus.opcode), bus.s_bit);
                if (bus.mode == 2'b01) begin
                    m_wait   = 1;
                    m_waited = 0;
                end
            end else begin
                e = bub;
            end
        end else begin
            m_waited++;
            e.ill = 0;
            e.err = 0;
            if (bus.mem_ready) begin
                e      = bub;
                m_wait = 0;
            end else if (TO != 0 && m_waited == TO) begin
                e      = bub;
                e.err  = 1;
                m_wait = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("exe_cmd",   32'(bus.exe_cmd),   32'(e.cmd));
        chk("s_update",  32'(bus.s_update),  32'(e.s));
        chk("branch",    32'(bus.branch),    32'(e.br));
        chk("mem_w_en",  32'(bus.mem_w_en),  32'(e.mw));
        chk("mem_r_en",  32'(bus.mem_r_en),  32'(e.mr));
        chk("wb_en",     32'(bus.wb_en),     32'(e.wb));
        chk("valid_out", 32'(bus.valid_out), 32'(e.vo));
        chk("illegal",   32'(bus.illegal),   32'(e.ill));
        chk("mem_err",   32'(bus.mem_err),   32'(e.err));
        chk("freeze",    32'(bus.freeze),    32'(m_wait));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drv(input bit v, input bit f, input int md, input int op, input bit s, input bit rdy);
        bus.valid_in  = v;
        bus.flush     = f;
        bus.mode      = 2'(md);
        bus.opcode    = 4'(op);
        bus.s_bit     = s;
        bus.mem_ready = rdy;
    endtask

    initial begin
        e        = '{default: 0};
        m_wait   = 0;
        m_waited = 0;
        rst      = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        cycle();
        chk("reset_valid", 32'(bus.valid_out), 0);

        // ADD with S
        drv(1, 0, 0, 4'b0100, 1, 0);
        cycle();
        chk("add_cmd", 32'(bus.exe_cmd), 2);
        chk("add_s", 32'(bus.s_update), 1);
        chk("add_freeze", 32'(bus.freeze), 0);

        // CMP / TST
        drv(1, 0, 0, 4'b1010, 0, 0);
        cycle();
        chk("cmp_cmd", 32'(bus.exe_cmd), 4);
        chk("cmp_s", 32'(bus.s_update), 1);
        chk("cmp_wb", 32'(bus.wb_en), 0);
        drv(1, 0, 0, 4'b1000, 0, 0);
        cycle();
        chk("tst_cmd", 32'(bus.exe_cmd), 6);

        // LDR with ready after 3 low cycles; new ADD offered throughout
        drv(1, 0, 1, 0, 1, 0);
        cycle();
        drv(1, 0, 0, 4'b0100, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ldr_hold_r", 32'(bus.mem_r_en), 1);
            chk("ldr_freeze", 32'(bus.freeze), 1);
        end
        bus.mem_ready = 1'b1;
        cycle();
        chk("ldr_bubble", 32'(bus.valid_out), 0);
        chk("ldr_unfreeze", 32'(bus.freeze), 0);
        bus.mem_ready = 1'b0;
        cycle();
        chk("post_ldr_add", 32'(bus.valid_out), 1);

        // STR timeout
        drv(1, 0, 1, 0, 0, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("str_hold_w", 32'(bus.mem_w_en), 1);
        end
        cycle();
        chk("str_timeout_err", 32'(bus.mem_err), 1);
        chk("str_timeout_w", 32'(bus.mem_w_en), 0);
        cycle();
        chk("str_err_pulse", 32'(bus.mem_err), 0);

        // flush beats valid; illegal encodings
        drv(1, 1, 0, 4'b0100, 1, 0);
        cycle();
        chk("flush_bubble", 32'(bus.valid_out), 0);
        drv(1, 0, 3, 0, 1, 0);
        cycle();
        chk("mode3_illegal", 32'(bus.illegal), 1);
        drv(1, 0, 0, 4'b0011, 1, 0);
        cycle();
        chk("op3_illegal", 32'(bus.illegal), 1);
        chk("op3_wb", 32'(bus.wb_en), 0);

        // flush during wait is ignored
        drv(1, 0, 1, 0, 1, 0);
        cycle();
        drv(1, 1, 0, 0, 0, 0);
        cycle();
        chk("flush_wait_hold", 32'(bus.mem_r_en), 1);
        bus.mem_ready = 1'b1;
        cycle();
        chk("flush_wait_done", 32'(bus.freeze), 0);

        // reset in the second wait cycle
        drv(1, 0, 1, 0, 1, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_wait_freeze", 32'(bus.freeze), 0);
        chk("rst_wait_err", 32'(bus.mem_err), 0);
        rst = 1'b0;
        drv(1, 0, 1, 0, 1, 0);
        cycle();
        chk("ldr_restart", 32'(bus.freeze), 1);
        drv(0, 0, 0, 0, 0, 1);
        cycle();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drv(($urandom % 4) != 0, ($urandom % 8) == 0, int'($urandom % 4),
                int'($urandom % 16), 1'($urandom), ($urandom % 4) == 0);
            cycle();
            if (bus.illegal === 1'b1 && bus.mem_err === 1'b1)
                chk("ill_err_excl", 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_unit_seq.md
Name: ctrl_unit_seq

Overview:
- Registered, parametrised successor to the combinational ARM instruction control decoder.
- Decodes mode/opcode/S into execute command and stage enables, registers them into the ID/EX boundary, and sequences multi-cycle memory accesses.
- Freezes upstream while a load/store waits for memory ready, with a timeout.
- Sits at the end of the ID stage, feeding the ID/EX register and hazard/freeze logic.

Parameters:
- EXE_CMD_W, 4: width of exe_cmd. Must be >=4; the 4-bit codes below are zero-extended.
- MEM_TIMEOUT, 16: max MEM_WAIT cycles before mem_err. 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  instruction fields valid this cycle
- flush  in  1  squash current instruction (branch taken)
- mode  in  2  instruction mode field
- opcode  in  4  instruction opcode field
- s_bit  in  1  S bit (L bit in mode 01)
- mem_ready  in  1  data memory access complete
- exe_cmd  out  EXE_CMD_W  registered ALU command
- s_update  out  1  registered status-update enable
- branch  out  1  registered branch
- mem_w_en  out  1  registered memory write
- mem_r_en  out  1  registered memory read
- wb_en  out  1  registered writeback enable
- valid_out  out  1  registered outputs are a live instruction
- illegal  out  1  one-cycle pulse: undecodable instruction accepted
- freeze  out  1  combinational; high while state==MEM_WAIT
- mem_err  out  1  one-cycle pulse: memory timeout

Behaviour:
- Reset: state=RUN, counter=0, all outputs 0.
- Decode table, mode 00. Each opcode -> cmd, s_update, wb:
  - 1101 -> 0001, S, 1
  - 1111 -> 1001, S, 1
  - 0100 -> 0010, S, 1
  - 0101 -> 0011, S, 1
  - 0010 -> 0100, S, 1
  - 0110 -> 0101, S, 1
  - 0000 -> 0110, S, 1
  - 1100 -> 0111, S, 1
  - 0001 -> 1000, S, 1
  - 1010 -> 0100, 1, 0
  - 1000 -> 0110, 1, 0
  - Any other opcode: illegal.
- Mode 01: cmd 0010.
  - s_bit=1: mem_r_en=1, wb_en=1.
  - s_bit=0: mem_w_en=1, wb_en=0.
- Mode 10: cmd 0000, branch=1, all else 0.
- Mode 11: illegal.
- Illegal instructions: all control outputs 0, valid_out=1, illegal=1 for one cycle. No z or x is ever driven.
- State RUN, per edge:
  - If valid_in & !flush: load decoded outputs (latency 1 cycle), valid_out=1. If mode==01, go to MEM_WAIT and clear the counter.
  - Otherwise: load a bubble (all outputs 0, valid_out=0).
  - flush has priority over valid_in.
- State MEM_WAIT:
  - Registered outputs are held unchanged. freeze=1. valid_in and flush are ignored; an access in flight always completes.
  - On each edge:
    - mem_ready=1: load bubble, go to RUN, freeze drops. The next instruction is accepted one edge later, giving exactly one bubble cycle.
    - Else, if MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT-1: load bubble, mem_err=1 for one cycle, go to RUN.
    - Else: counter+1.
  - If mem_ready and timeout coincide, mem_ready wins and mem_err=0.
- rst during MEM_WAIT: back to RUN, everything zeroed on that edge. No mem_err.
- mem_ready is ignored in RUN.
- illegal and mem_err are never high together; both deassert on the following edge.

Test Plan:
- ADD with S: reset, then valid_in=1, mode=00, opcode=0100, s_bit=1 -> next cycle exe_cmd=0010, s_update=1, wb_en=1, valid_out=1, freeze=0.
- CMP/TST: opcode 1010, s_bit=0 -> exe_cmd=0100, s_update=1, wb_en=0. Opcode 1000 -> exe_cmd=0110, s_update=1.
- LDR with delayed ready: mode=01, s_bit=1, mem_ready low for 3 cycles then high.
  - mem_r_en=1, wb_en=1 and freeze=1 for 4 cycles.
  - Then a bubble cycle with valid_out=0, then a new ADD is accepted.
- STR timeout: MEM_TIMEOUT=4, mode=01, s_bit=0, mem_ready held 0 -> mem_w_en=1 for 4 cycles, then mem_err pulses once and outputs go to 0.
- Flush vs illegal:
  - valid_in=1, flush=1 with an ADD -> bubble.
  - mode=11 -> illegal pulse, all enables 0.
  - mode=00, opcode=0011 -> illegal pulse.
  - flush asserted during MEM_WAIT -> ignored, access still completes on mem_ready.
- Reset mid-wait: rst=1 in the 2nd MEM_WAIT cycle -> all outputs 0 and freeze=0 next cycle, no mem_err. Then LDR restarts normally.
